// File: rtl/tc_pkg.sv
// Shared types and helpers for the countdown timer and the bridge that decodes it.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tc_pkg;

    // Timer sequencing: idle, load preset, count down, signal interrupt.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } tc_state_t;

    // Word index within the 16-byte register window (addr[3:2]).
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;

    // CTRL.MODE encodings; anything other than RELOAD runs as one-shot.
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    // CTRL register layout as it sits in bits [3:0] of the word.
    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } tc_ctrl_t;

    // Byte-lane write merge: each set byteen bit replaces that byte of old_dat.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_dat,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  byteen);
        logic [31:0] merged;
        merged = old_dat;
        for (int i = 0; i < 4; i++) begin
            if (byteen[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/tc_timer_if.sv
// CPU data-port view of the timer: address, byte enables, write data, read data, irq.
// Latency: rdata combinational from addr; writes land on the next rising edge.
// Backpressure: none; the slave accepts every access in the cycle it is presented.
interface tc_timer_if;

    logic [31:0] addr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (
        output addr,
        output byteen,
        output wdata,
        input  rdata,
        input  irq
    );

    modport slave (
        input  addr,
        input  byteen,
        input  wdata,
        output rdata,
        output irq
    );

endinterface

// File: rtl/tc_timer.sv
// Memory-mapped countdown timer with one-shot and auto-reload modes and a maskable irq.
// Latency: irq_flag rises N+2 edges after the EN write (N=PRESET>=1; 3 edges for N=0).
// Backpressure: none; register reads are combinational and writes always complete.
module tc_timer
    import tc_pkg::*;
#(
    parameter logic [31:0] BASE = 32'h0000_7F00
) (
    input  logic       clk,
    input  logic       reset,
    tc_timer_if.slave  bus
);

    // Register state.
    tc_ctrl_t    ctrl_q;
    logic [31:0] preset_q;
    logic [31:0] count_q;
    tc_state_t   state_q;
    logic        irq_flag_q;
    logic        irq_q;

    // Next-state values.
    tc_ctrl_t    ctrl_n;
    logic [31:0] preset_n;
    logic [31:0] count_n;
    tc_state_t   state_n;
    logic        irq_flag_n;

    // Decode.
    logic        sel;
    logic [1:0]  reg_idx;
    logic        wr_hit;
    logic        ctrl_wr;
    logic        preset_wr;
    logic [31:0] ctrl_word;
    logic [31:0] ctrl_merged;
    logic [31:0] preset_merged;
    logic        addr_lsb_unused;

    // Word accesses only: the byte offset within the word carries no meaning.
    assign addr_lsb_unused = ^bus.addr[1:0];

    assign sel       = (bus.addr[31:4] == BASE[31:4]);
    assign reg_idx   = bus.addr[3:2];
    assign wr_hit    = sel && (|bus.byteen);
    assign ctrl_wr   = wr_hit && (reg_idx == REG_CTRL);
    assign preset_wr = wr_hit && (reg_idx == REG_PRESET);

    // CTRL occupies only the low nibble; the upper bits read as zero and are
    // therefore merged as zero so a partial write never resurrects them.
    assign ctrl_word     = {28'd0, ctrl_q};
    assign ctrl_merged   = byte_merge(ctrl_word, bus.wdata, bus.byteen);
    assign preset_merged = byte_merge(preset_q, bus.wdata, bus.byteen);

    // Next-state: sequencer step first, then CPU writes override (CPU wins on
    // CTRL, and a CTRL write always acknowledges a pending irq_flag).
    always_comb begin
        state_n    = state_q;
        ctrl_n     = ctrl_q;
        preset_n   = preset_q;
        count_n    = count_q;
        irq_flag_n = irq_flag_q;

        case (state_q)
            ST_IDLE: begin
                if (ctrl_q.en) begin
                    state_n = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // LOAD always completes, even if EN was just dropped.
                count_n = preset_q;
                state_n = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q.en) begin
                    state_n = ST_IDLE;
                end else if (count_q > 32'd1) begin
                    count_n = count_q - 32'd1;
                end else begin
                    // Terminal count; also covers a zero preset so COUNT never wraps.
                    count_n    = 32'd0;
                    irq_flag_n = 1'b1;
                    state_n    = ST_INT;
                end
            end
            ST_INT: begin
                if (ctrl_q.en && (ctrl_q.mode == MODE_RELOAD)) begin
                    // Periodic: drop the flag so irq is a single-cycle pulse.
                    irq_flag_n = 1'b0;
                    state_n    = ST_LOAD;
                end else begin
                    // One-shot (or disabled): park, self-clear EN, keep the flag.
                    ctrl_n.en = 1'b0;
                    state_n   = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (ctrl_wr) begin
            ctrl_n     = tc_ctrl_t'(ctrl_merged[3:0]);
            irq_flag_n = 1'b0;
        end

        if (preset_wr) begin
            preset_n = preset_merged;
        end
    end

    // Register update; irq is registered from the post-edge flag and mask.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            state_q    <= ST_IDLE;
            irq_flag_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_n;
            preset_q   <= preset_n;
            count_q    <= count_n;
            state_q    <= state_n;
            irq_flag_q <= irq_flag_n;
            irq_q      <= irq_flag_n & ctrl_n.im;
        end
    end

    // Combinational read mux; unselected addresses and index 3 return zero.
    always_comb begin
        bus.rdata = 32'd0;
        if (sel) begin
            case (reg_idx)
                REG_CTRL:   bus.rdata = ctrl_word;
                REG_PRESET: bus.rdata = preset_q;
                REG_COUNT:  bus.rdata = count_q;
                default:    bus.rdata = 32'd0;
            endcase
        end
    end

    assign bus.irq = irq_q;

endmodule

// File: tb/tb_tc_timer.sv
// Self-checking bench for tc_timer: register table, directed timing sequences, random vs model.
// Latency: n/a.
// Backpressure: n/a.
module tb_tc_timer;

    localparam logic [31:0] BASE = 32'h0000_7F00;

    localparam int PH_IDLE = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_CNT  = 2;
    localparam int PH_INT  = 3;

    logic clk = 1'b0;
    logic reset;

    tc_timer_if bus ();

    tc_timer #(.BASE(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural reference: register file plus a phase number per the timer rules.
    int unsigned m_ctrl;
    int unsigned m_preset;
    int unsigned m_count;
    int          m_phase;
    bit          m_flag;
    bit          m_irq;

    typedef struct {
        logic [31:0] waddr;
        logic [3:0]  be;
        logic [31:0] wdat;
        logic [31:0] raddr;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vt[$];

    function automatic int unsigned merge(int unsigned old_v, int unsigned new_v, logic [3:0] be);
        int unsigned r;
        int unsigned mask;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                mask = 32'hFF << (8 * i);
                r = (r & ~mask) | (new_v & mask);
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        m_ctrl = 0; m_preset = 0; m_count = 0;
        m_phase = PH_IDLE; m_flag = 1'b0; m_irq = 1'b0;
    endtask

    function automatic int unsigned model_read(logic [31:0] a);
        if (a[31:4] != BASE[31:4]) return 0;
        case (a[3:2])
            2'd0:    return m_ctrl;
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 0;
        endcase
    endfunction

    // Advance the reference by one clock edge using the inputs currently on the bus.
    task automatic model_step();
        bit          hit;
        int unsigned idx;
        int unsigned c, p, n;
        int          ph;
        bit          f, en, periodic;
        hit = (bus.addr[31:4] == BASE[31:4]);
        idx = 32'(bus.addr[3:2]);
        c = m_ctrl; p = m_preset; n = m_count; ph = m_phase; f = m_flag;
        en = m_ctrl[0];
        periodic = (m_ctrl[2:1] == 2'b01);
        if (m_phase == PH_IDLE) begin
            if (en) ph = PH_LOAD;
        end else if (m_phase == PH_LOAD) begin
            n = m_preset; ph = PH_CNT;
        end else if (m_phase == PH_CNT) begin
            if (!en) ph = PH_IDLE;
            else if (m_count >= 2) n = m_count - 1;
            else begin n = 0; f = 1'b1; ph = PH_INT; end
        end else begin
            if (en && periodic) begin ph = PH_LOAD; f = 1'b0; end
            else begin ph = PH_IDLE; c = c & 32'hE; end
        end
        if (hit && bus.byteen != 4'd0) begin
            if (idx == 0) begin
                c = merge(m_ctrl, bus.wdata, bus.byteen) & 32'hF;
                f = 1'b0;
            end else if (idx == 1) begin
                p = merge(m_preset, bus.wdata, bus.byteen);
            end
        end
        m_ctrl = c; m_preset = p; m_count = n; m_phase = ph; m_flag = f;
        m_irq = f & c[3];
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(logic [31:0] a, logic [31:0] d, logic [3:0] be);
        bus.addr = a; bus.wdata = d; bus.byteen = be;
        tick();
        bus.byteen = 4'd0;
    endtask

    task automatic rd_chk(string name, logic [31:0] a, logic [31:0] exp);
        bus.addr = a;
        #1;
        chk(name, bus.rdata, exp);
    endtask

    task automatic add_vec(logic [31:0] wa, logic [3:0] be, logic [31:0] wd,
                           logic [31:0] ra, logic [31:0] ex, string nm);
        vec_t v;
        v.waddr = wa; v.be = be; v.wdat = wd; v.raddr = ra; v.exp = ex; v.name = nm;
        vt.push_back(v);
    endtask

    initial begin
        bit saw_two;
        bit saw_zero;
        logic [31:0] a;
        int unsigned r;

        reset = 1'b1;
        bus.addr = BASE; bus.byteen = 4'd0; bus.wdata = 32'd0;
        model_reset();
        #12;
        rd_chk("reset_ctrl",   BASE,        32'd0);
        rd_chk("reset_preset", BASE + 32'h4, 32'd0);
        rd_chk("reset_count",  BASE + 32'h8, 32'd0);
        chk("reset_irq", bus.irq, 32'd0);
        reset = 1'b0;

        // Register access table.
        add_vec(BASE + 32'h4,  4'hF, 32'h1122_3344, BASE + 32'h4,  32'h1122_3344, "preset_full");
        add_vec(BASE + 32'h4,  4'h5, 32'hAABB_CCDD, BASE + 32'h4,  32'h11BB_33DD, "preset_be0101");
        add_vec(BASE + 32'h8,  4'hF, 32'hFFFF_FFFF, BASE + 32'h8,  32'h0,         "count_ro");
        add_vec(BASE + 32'hC,  4'hF, 32'hFFFF_FFFF, BASE + 32'hC,  32'h0,         "idx3_zero");
        add_vec(BASE + 32'h10, 4'hF, 32'hFFFF_FFFF, BASE + 32'h10, 32'h0,         "above_window");
        add_vec(BASE + 32'h14, 4'hF, 32'h0,         BASE + 32'h4,  32'h11BB_33DD, "preset_kept");
        add_vec(BASE - 32'h4,  4'hF, 32'hFFFF_FFFF, BASE - 32'h4,  32'h0,         "below_window");
        add_vec(BASE,          4'hF, 32'hFFFF_FFF0, BASE,          32'h0,         "ctrl_upper_zero");
        add_vec(BASE,          4'h2, 32'h0000_FFFF, BASE,          32'h0,         "ctrl_byte1_only");
        add_vec(BASE,          4'h1, 32'h0000_00F8, BASE,          32'h8,         "ctrl_im_only");
        add_vec(BASE + 32'h2,  4'h1, 32'h0,         BASE,          32'h0,         "ctrl_lsb_ignored");
        for (int i = 0; i < vt.size(); i++) begin
            wr(vt[i].waddr, vt[i].wdat, vt[i].be);
            rd_chk(vt[i].name, vt[i].raddr, vt[i].exp);
            chk({vt[i].name, "_irq"}, bus.irq, 32'd0);
        end

        // One-shot, PRESET=3: COUNT 3,2,1,0 at E2..E5, irq from E5, EN self-clears at E6.
        wr(BASE + 32'h4, 32'd3, 4'hF);
        wr(BASE, 32'h9, 4'hF);
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k >= 2) rd_chk("oneshot_count", BASE + 32'h8, 32'(5 - k));
            chk("oneshot_irq", bus.irq, (k == 5) ? 32'd1 : 32'd0);
        end
        tick();
        rd_chk("oneshot_ctrl_e6", BASE, 32'h8);
        chk("oneshot_irq_e6", bus.irq, 32'd1);
        tick();
        chk("oneshot_irq_hold", bus.irq, 32'd1);
        wr(BASE, 32'h8, 4'hF);
        chk("oneshot_ack", bus.irq, 32'd0);

        // Auto-reload, PRESET=2: single-cycle pulse every 4 edges.
        wr(BASE + 32'h4, 32'd2, 4'hF);
        wr(BASE, 32'hB, 4'hF);
        for (int k = 1; k <= 13; k++) begin
            tick();
            chk("reload_irq", bus.irq, (k % 4 == 0) ? 32'd1 : 32'd0);
        end
        wr(BASE, 32'h3, 4'hF);
        saw_two = 1'b0; saw_zero = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("reload_masked_irq", bus.irq, 32'd0);
            bus.addr = BASE + 32'h8;
            #1;
            if (bus.rdata == 32'd2) saw_two = 1'b1;
            if (bus.rdata == 32'd0) saw_zero = 1'b1;
        end
        chk("reload_masked_cnt_hi", 32'(saw_two), 32'd1);
        chk("reload_masked_cnt_lo", 32'(saw_zero), 32'd1);
        wr(BASE, 32'h0, 4'hF);
        tick(); tick(); tick();

        // PRESET=0: irq after E3.
        wr(BASE + 32'h4, 32'd0, 4'hF);
        wr(BASE, 32'h9, 4'hF);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("preset0_irq", bus.irq, (k == 3) ? 32'd1 : 32'd0);
        end
        tick();
        wr(BASE, 32'h0, 4'hF);

        // PRESET rewritten mid-count only takes effect on the next reload.
        wr(BASE + 32'h4, 32'd5, 4'hF);
        wr(BASE, 32'h3, 4'hF);
        tick(); tick(); tick();
        rd_chk("midcnt_e3", BASE + 32'h8, 32'd4);
        wr(BASE + 32'h4, 32'd9, 4'hF);
        rd_chk("midcnt_e4", BASE + 32'h8, 32'd3);
        tick(); tick(); tick();
        rd_chk("midcnt_e7", BASE + 32'h8, 32'd0);
        tick(); tick();
        rd_chk("midcnt_reload", BASE + 32'h8, 32'd9);
        wr(BASE, 32'h0, 4'hF);
        tick(); tick(); tick();

        // CTRL write on the edge that sets irq_flag: the acknowledge wins.
        wr(BASE + 32'h4, 32'd2, 4'hF);
        wr(BASE, 32'h9, 4'hF);
        tick(); tick(); tick();
        wr(BASE, 32'h9, 4'hF);
        chk("coinc_irq_e4", bus.irq, 32'd0);
        tick();
        chk("coinc_irq_e5", bus.irq, 32'd0);
        rd_chk("coinc_ctrl_e5", BASE, 32'h8);

        // CTRL write on the INT edge that would self-clear EN: the CPU value wins.
        wr(BASE, 32'h9, 4'hF);
        tick(); tick(); tick(); tick();
        chk("cpuwins_irq_set", bus.irq, 32'd1);
        wr(BASE, 32'hD, 4'hF);
        rd_chk("cpuwins_ctrl", BASE, 32'hD);
        chk("cpuwins_irq_ack", bus.irq, 32'd0);
        wr(BASE, 32'h0, 4'hF);
        tick(); tick(); tick();

        // Reset asserted between edges while counting.
        wr(BASE + 32'h4, 32'd7, 4'hF);
        wr(BASE, 32'h9, 4'hF);
        tick(); tick(); tick();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        rd_chk("areset_ctrl",   BASE,          32'd0);
        rd_chk("areset_preset", BASE + 32'h4,  32'd0);
        rd_chk("areset_count",  BASE + 32'h8,  32'd0);
        chk("areset_irq", bus.irq, 32'd0);
        reset = 1'b0;
        tick();

        // Random traffic against the reference model.
        for (int i = 0; i < 2000; i++) begin
            a = BASE + 32'($urandom_range(0, 7) * 4);
            if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(0, 3));
            bus.addr = a;
            r = $urandom_range(0, 9);
            bus.byteen = (r >= 8) ? 4'($urandom_range(1, 15)) : 4'd0;
            if (a[3:2] == 2'd1 && $urandom_range(0, 9) != 0) bus.wdata = 32'($urandom_range(0, 6));
            else bus.wdata = $urandom;
            #1;
            chk("rnd_rdata", bus.rdata, model_read(bus.addr));
            chk("rnd_irq", bus.irq, 32'(m_irq));
            tick();
        end
        bus.byteen = 4'd0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
